mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped UART transmitter.
// Holds the transmitter state encoding, register offsets and STATUS bit
// positions. Optional feature macro: UART_TX_PARITY_EN (adds the PARITY
// state and the even-parity helper).
package mmio_pkg;

    // Register map (byte offsets); only address bit 2 distinguishes them.
    localparam logic [31:0] TXDATA_OFS  = 32'h0;
    localparam logic [31:0] STATUS_OFS  = 32'h4;
    localparam int          REG_SEL_BIT = 2;

    // STATUS register bit positions.
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    // Serial frame bit count.
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Transmitter states. PARITY only exists when the parity option is built.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with push/pop, full/empty flags and an
// occupancy count. The head entry is presented combinationally so a byte
// written in one cycle can be popped by the transmitter in the next.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against pushing into a full FIFO or popping an empty one.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small transmit FIFO.
// TXDATA (offset 0x0) queues a byte; STATUS (offset 0x4) reports
// {overflow, tx_busy, empty, full}, and any write to it clears overflow.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        TxD
);

    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] TIMER_RELOAD = 16'(CLK_DIV - 1);

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_overflow;

    logic          w_sel_status;
    logic          w_sel_txdata;
    logic          w_wr_txdata;
    logic          w_wr_status;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_fifo_rdata;
    logic [CW-1:0] w_fifo_count;
    logic          w_timer_done;
    logic          w_state_entry;
    logic          w_busy;
    logic [31:0]   w_status;
    logic          w_unused;

    // Only Addr[2] selects a register; the rest of the address and the upper
    // store data are intentionally ignored.
    assign w_unused = &{1'b0, Addr[31:3], Addr[1:0], WData[31:8], w_fifo_count};

    assign w_sel_status = (Addr[REG_SEL_BIT] == STATUS_OFS[REG_SEL_BIT]);
    assign w_sel_txdata = (Addr[REG_SEL_BIT] == TXDATA_OFS[REG_SEL_BIT]);
    assign w_wr_txdata  = CS && MemWrite && w_sel_txdata;
    assign w_wr_status  = CS && MemWrite && w_sel_status;

    // A write that finds the FIFO full is dropped, even if a pop happens in
    // the same cycle.
    assign w_push = w_wr_txdata && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (w_push),
        .i_wdata (WData[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign w_timer_done  = (r_timer == 16'd0);
    assign w_state_entry = (w_state_next != r_state);

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: each serial state lasts CLK_DIV cycles per bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_timer_done) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_timer_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_timer_done) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_timer_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: serial line level per state and the busy flag.
    always_comb begin
        TxD    = 1'b1;
        w_busy = (r_state != ST_IDLE);
        case (r_state)
            ST_START:  TxD = 1'b0;
            ST_DATA:   TxD = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: TxD = even_parity(r_shift);
`endif
            default:   TxD = 1'b1;
        endcase
    end

    // Bit timer, data bit index and shift register. The timer reloads on
    // every state change and at each data-bit boundary.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (w_state_entry || ((r_state == ST_DATA) && w_timer_done)) begin
                r_timer <= TIMER_RELOAD;
            end else if (!w_timer_done) begin
                r_timer <= r_timer - 16'd1;
            end

            if ((w_state_next == ST_DATA) && (r_state != ST_DATA)) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_timer_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_pop) begin
                r_shift <= w_fifo_rdata;
            end
        end
    end

    // Sticky overflow flag: set by a dropped TXDATA write, cleared by any
    // STATUS write.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_overflow <= 1'b0;
        end else if (w_wr_txdata && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_wr_status) begin
            r_overflow <= 1'b0;
        end
    end

    // Register read mux: TXDATA reads as zero, nothing is driven unless selected.
    always_comb begin
        w_status                 = 32'd0;
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_BUSY_BIT]  = w_busy;
        w_status[STAT_OVF_BIT]   = r_overflow;
        RData                    = 32'd0;
        if (CS && w_sel_status) begin
            RData = w_status;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx (CLK_DIV=4,
// FIFO_DEPTH=4). A line receiver turns TxD back into bytes; expected bytes,
// frame waveforms and STATUS values are computed from the register and frame
// rules. Honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_mmio_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CLK_DIV;
    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;

    logic        CLK      = 1'b0;
    logic        RST      = 1'b0;
    logic        CS       = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr     = 32'd0;
    logic [31:0] WData    = 32'd0;
    logic [31:0] RData;
    logic        TxD;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    int         rx_err = 0;
    int         rx_rd  = 0;

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CS       (CS),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WData    (WData),
        .RData    (RData),
        .TxD      (TxD)
    );

    always #5 CLK = ~CLK;

    // Line receiver: on a low level, sample FB bits of CLK_DIV cycles each;
    // every sample of a bit must agree. Frames cut short by reset are dropped.
    always begin : rx_monitor
        logic [FB-1:0] bv;
        bit            steady;
        bit            aborted;
        @(negedge CLK);
        if (RST === 1'b1 && TxD === 1'b0) begin
            steady  = 1'b1;
            aborted = 1'b0;
            bv      = '0;
            for (int k = 0; k < FB; k++) begin
                for (int j = 0; j < CLK_DIV; j++) begin
                    if (k != 0 || j != 0) @(negedge CLK);
                    if (RST !== 1'b1) aborted = 1'b1;
                    if (j == 0) bv[k] = TxD;
                    else if (TxD !== bv[k]) steady = 1'b0;
                end
            end
            if (!aborted) begin
                rx_q.push_back(bv[8:1]);
                if (!steady || bv[0] !== 1'b0 || bv[FB-1] !== 1'b1) rx_err++;
`ifdef UART_TX_PARITY_EN
                if (bv[9] !== ^bv[8:1]) rx_err++;
`endif
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input bit ovf, input bit busy,
                                              input bit empty, input bit full);
        return {28'd0, ovf, busy, empty, full};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        CS = 1'b1; MemWrite = 1'b1; Addr = a; WData = d;
        @(negedge CLK);
        CS = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        CS = 1'b1; MemWrite = 1'b0; Addr = a;
        #1;
        d  = RData;
        CS = 1'b0;
    endtask

    task automatic expect_rx(input logic [7:0] b, input string tag);
        if (rx_q.size() > rx_rd) chk(tag, 64'(rx_q[rx_rd]), 64'(b));
        else chk({tag, "_missing"}, 64'(rx_q.size()), 64'(rx_rd + 1));
        rx_rd++;
    endtask

    // Write one byte while idle and compare 64 cycles of TxD with the frame
    // built from the bit rules (start, LSB-first data, [parity], stop).
    task automatic frame_trace(input logic [7:0] b, input string tag);
        logic [FB-1:0] fbits;
        logic [63:0]   obs;
        logic [63:0]   exp;
        logic [31:0]   rd;
        fbits      = '0;
        fbits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        fbits[9]   = ^b;
`endif
        fbits[FB-1] = 1'b1;
        exp = '1;
        for (int i = 1; i <= FRAME_CYC; i++) exp[i] = fbits[(i - 1) / CLK_DIV];
        bus_write(A_TXDATA, ($urandom & 32'hFFFF_FF00) | 32'(b));
        obs = '0;
        for (int i = 0; i < 64; i++) begin
            obs[i] = TxD;
            @(negedge CLK);
        end
        chk({tag, "_wave"}, obs, exp);
        bus_read(A_STATUS, rd);
        chk({tag, "_status"}, 64'(rd), 64'(status_of(0, 0, 1, 0)));
        expect_rx(b, {tag, "_rx"});
        chk({tag, "_rxcount"}, 64'(rx_q.size()), 64'(rx_rd));
    endtask

    // Burst of n back-to-back TXDATA writes starting from idle. The first
    // byte leaves the FIFO at once, DEPTH more fit, the rest are dropped.
    task automatic burst_test(input int n, input bit last_aa, input string tag);
        logic [7:0]  sent[$];
        logic [7:0]  b;
        logic [31:0] rd;
        int          accepted;
        int          cnt;
        bit          ovf;
        int          base;
        base = rx_q.size();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (last_aa && i == n - 1) b = 8'hAA;
            sent.push_back(b);
            CS = 1'b1; MemWrite = 1'b1;
            Addr  = $urandom & ~32'h4;
            WData = ($urandom & 32'hFFFF_FF00) | 32'(b);
            @(negedge CLK);
        end
        CS = 1'b0; MemWrite = 1'b0;
        accepted = (n < DEPTH + 1) ? n : DEPTH + 1;
        ovf      = (n > DEPTH + 1);
        cnt      = accepted - 1;
        @(negedge CLK);
        bus_read(A_STATUS, rd);
        chk({tag, "_status"}, 64'(rd), 64'(status_of(ovf, 1, cnt == 0, cnt == DEPTH)));
        bus_write(($urandom & ~32'h4) | A_STATUS, $urandom);
        bus_read(A_STATUS, rd);
        chk({tag, "_status_clr"}, 64'(rd), 64'(status_of(0, 1, cnt == 0, cnt == DEPTH)));
        repeat (accepted * (FRAME_CYC + 1) + 10) @(negedge CLK);
        bus_read(A_STATUS, rd);
        chk({tag, "_status_end"}, 64'(rd), 64'(status_of(0, 0, 1, 0)));
        chk({tag, "_rxcount"}, 64'(rx_q.size() - base), 64'(accepted));
        for (int i = 0; i < accepted; i++) expect_rx(sent[i], $sformatf("%s_byte%0d", tag, i));
        $display("burst %s n=%0d accepted=%0d overflow=%0d", tag, n, accepted, ovf);
    endtask

    initial begin : main
        logic [31:0] rd;
        bit          low_seen;
        int          base;

        // Reset state.
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_txd", 64'(TxD), 64'(1'b1));
        bus_read(A_STATUS, rd);
        chk("reset_status", 64'(rd), 64'(status_of(0, 0, 1, 0)));
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Unselected write is ignored and reads back zero.
        CS = 1'b0; MemWrite = 1'b1; Addr = A_TXDATA; WData = $urandom;
        #1;
        chk("cs0_rdata", 64'(RData), 64'd0);
        @(negedge CLK);
        MemWrite = 1'b0;
        bus_read(A_STATUS, rd);
        chk("cs0_status", 64'(rd), 64'(status_of(0, 0, 1, 0)));
        bus_read(A_TXDATA, rd);
        chk("txdata_read", 64'(rd), 64'd0);
        repeat (FRAME_CYC + 10) @(negedge CLK);
        chk("cs0_no_frame", 64'(rx_q.size()), 64'(rx_rd));

        // Exact frame waveforms.
        frame_trace(8'h55, "frame55");
        frame_trace(8'h07, "frame07");
        frame_trace(8'h03, "frame03");

        // Five writes fill the FIFO without overflow; six overflow and the
        // sixth byte (0xAA) must never be sent.
        burst_test(DEPTH + 1, 1'b0, "fill");
        burst_test(DEPTH + 2, 1'b1, "overflow");
        for (int it = 0; it < 6; it++) begin
            burst_test($urandom_range(1, DEPTH + 3), 1'b0, $sformatf("rand%0d", it));
        end

        // Reset during the data bits of 0x3C with two bytes queued.
        base = rx_q.size();
        bus_write(A_TXDATA, 32'h3C);
        bus_write(A_TXDATA, 32'h81);
        bus_write(A_TXDATA, 32'hE7);
        repeat (4) @(negedge CLK);
        chk("rst_pre_txd", 64'(TxD), 64'(1'b0));
        RST = 1'b0;
        #1;
        chk("rst_async_txd", 64'(TxD), 64'(1'b1));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        bus_read(A_STATUS, rd);
        chk("rst_status", 64'(rd), 64'(status_of(0, 0, 1, 0)));
        low_seen = 1'b0;
        repeat (3 * FRAME_CYC) begin
            @(negedge CLK);
            if (TxD !== 1'b1) low_seen = 1'b1;
        end
        chk("rst_txd_idle", 64'(low_seen), 64'd0);
        chk("rst_no_rx", 64'(rx_q.size() - base), 64'd0);
        rx_rd = rx_q.size();

        chk("rx_frame_errors", 64'(rx_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
